// File: rtl/parity_check_stage.sv
// parity_check_stage
//   Sits directly downstream of the parity generator. Each incoming word has
//   its parity rechecked. The word and its mismatch flag are forwarded through
//   a 2-entry skid buffer, which lets in_ready come straight from a flop.
//   A saturating error counter and a sticky error flag give status readout.
//
// Ports
//   clk        : clock, all logic on rising edge
//   rst        : synchronous active-high reset
//   in_valid   : upstream word valid
//   in_ready   : stage can accept a word (registered)
//   in_data    : data word [WIDTH]
//   in_parity  : parity bit produced upstream
//   out_valid  : downstream word valid
//   out_ready  : downstream accepts word
//   out_data   : forwarded data word [WIDTH]
//   out_error  : parity mismatch for the word on out_data
//   err_count  : mismatched words accepted, saturating [CNT_WIDTH]
//   err_sticky : set on any accepted mismatch, held until cleared
//   clr_err    : synchronous clear of err_count and err_sticky
module parity_check_stage #(
  parameter int WIDTH     = 8,
  parameter bit ODD       = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_error,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic parity_err(input logic [WIDTH-1:0] data,
                                      input logic             par);
    return (^data) ^ par ^ ODD;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
  endfunction

  // ---- stage p0: input check and handshake decode ----
  logic       err_p0;
  logic       accept_p0;
  logic       xfer_p0;
  logic [1:0] count_next;

  logic [1:0]       count_p1;
  logic [WIDTH-1:0] head_data_p1;
  logic             head_err_p1;
  logic [WIDTH-1:0] tail_data_p1;
  logic             tail_err_p1;
  logic             ready_p1;

  assign err_p0    = parity_err(in_data, in_parity);
  assign accept_p0 = in_valid && ready_p1;
  assign xfer_p0   = out_valid && out_ready;

  always_comb begin
    count_next = count_p1;
    case ({accept_p0, xfer_p0})
      2'b10:   count_next = count_p1 + 2'd1;
      2'b01:   count_next = count_p1 - 2'd1;
      default: count_next = count_p1;
    endcase
  end

  // ---- stage p1: skid buffer (head feeds the outputs) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1     <= 2'd0;
      ready_p1     <= 1'b1;
      head_data_p1 <= '0;
      head_err_p1  <= 1'b0;
    end else begin
      count_p1 <= count_next;
      // Registered, so in_ready never has a combinational path from out_ready.
      ready_p1 <= (count_next < 2'd2);
      if (count_p1 == 2'd2 && xfer_p0) begin
        head_data_p1 <= tail_data_p1;
        head_err_p1  <= tail_err_p1;
      end else if (accept_p0 && (count_p1 == 2'd0 || (count_p1 == 2'd1 && xfer_p0))) begin
        head_data_p1 <= in_data;
        head_err_p1  <= err_p0;
      end
    end
  end

  // Tail only ever holds a word that is behind a valid head; its contents
  // are don't-care while unoccupied, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept_p0 && count_p1 == 2'd1 && !xfer_p0) begin
      tail_data_p1 <= in_data;
      tail_err_p1  <= err_p0;
    end
  end

  // Error status counts at accept time; a clear in the same cycle as an
  // erroneous accept is applied first, leaving a count of one.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else if (clr_err) begin
      err_count  <= (accept_p0 && err_p0) ? CNT_WIDTH'(1) : '0;
      err_sticky <= accept_p0 && err_p0;
    end else if (accept_p0 && err_p0) begin
      err_count  <= sat_inc(err_count);
      err_sticky <= 1'b1;
    end
  end

  assign in_ready  = ready_p1;
  assign out_valid = (count_p1 != 2'd0);
  assign out_data  = head_data_p1;
  assign out_error = head_err_p1;

endmodule

// File: tb/tb_parity_check_stage.sv
module tb_parity_check_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       in_parity [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       out_error [2];
  logic       err_sticky[2];
  logic       clr_err   [2];
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  parity_check_stage #(.WIDTH(8), .ODD(1'b0), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_parity(in_parity[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_error(out_error[0]),
    .err_count(cnt0), .err_sticky(err_sticky[0]), .clr_err(clr_err[0])
  );

  parity_check_stage #(.WIDTH(8), .ODD(1'b1), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_parity(in_parity[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_error(out_error[1]),
    .err_count(cnt1), .err_sticky(err_sticky[1]), .clr_err(clr_err[1])
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic qpush(input int which, input logic [7:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    if (which == 0) q0.push_back(x);
    else            q1.push_back(x);
  endtask

  function automatic int qsize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  // Pops one expected word whenever the DUT is about to complete a transfer.
  task automatic monitor(input int which);
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid[which] && out_ready[which]) begin
        if (qsize(which) == 0) begin
          tests++;
          failed++;
          $display("FAIL u%0d unexpected output: got data=%0h err=%b, required no word",
                   which, out_data[which], out_error[which]);
        end else begin
          e = (which == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("u%0d out_data", which), 32'(out_data[which]), 32'(e.data));
          chk($sformatf("u%0d out_error", which), 32'(out_error[which]), 32'(e.err));
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers a word and returns at #1 after the edge that accepted it.
  task automatic push_word(input int which, input logic [7:0] d, input logic p,
                           input logic exp_err);
    int n;
    in_valid[which]  = 1'b1;
    in_data[which]   = d;
    in_parity[which] = p;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[which] && n < 20);
    if (!in_ready[which]) begin
      tests++;
      failed++;
      $display("FAIL u%0d accept timeout: got in_ready=0, required 1 within 20 cycles", which);
    end else begin
      qpush(which, d, exp_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while ((qsize(which) != 0 || out_valid[which]) && n < 30) begin
      cyc(1);
      n++;
    end
    chk($sformatf("u%0d drain pending words", which), 32'(qsize(which)), 32'd0);
  endtask

  logic [7:0] sat_d [5] = '{8'h00, 8'h01, 8'h03, 8'h80, 8'hFF};
  logic       sat_p [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] sat_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      in_parity[i] = 1'b0;
      out_ready[i] = 1'b0;
      clr_err[i]   = 1'b0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    cyc(2);
    chk("rst u0 out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst u0 in_ready", 32'(in_ready[0]), 32'd1);
    chk("rst u0 out_data", 32'(out_data[0]), 32'd0);
    chk("rst u0 err_count", 32'(cnt0), 32'd0);
    chk("rst u0 err_sticky", 32'(err_sticky[0]), 32'd0);
    chk("rst u1 out_valid", 32'(out_valid[1]), 32'd0);
    chk("rst u1 err_count", 32'(cnt1), 32'd0);
    rst = 1'b0;
    cyc(3);
    chk("idle u0 out_valid", 32'(out_valid[0]), 32'd0);
    chk("idle u0 in_ready", 32'(in_ready[0]), 32'd1);
    chk("idle u0 err_count", 32'(cnt0), 32'd0);

    // Streaming with out_ready high: each word visible right after its accept edge
    out_ready[0] = 1'b1;
    push_word(0, 8'hA5, 1'b0, 1'b0);
    chk("stream lat valid 1", 32'(out_valid[0]), 32'd1);
    chk("stream lat data 1", 32'(out_data[0]), 32'hA5);
    push_word(0, 8'h01, 1'b1, 1'b0);
    chk("stream lat data 2", 32'(out_data[0]), 32'h01);
    push_word(0, 8'h03, 1'b1, 1'b1);
    chk("stream lat data 3", 32'(out_data[0]), 32'h03);
    chk("stream lat err 3", 32'(out_error[0]), 32'd1);
    in_valid[0] = 1'b0;
    cyc(1);
    chk("stream err_count", 32'(cnt0), 32'd1);
    chk("stream err_sticky", 32'(err_sticky[0]), 32'd1);
    drain(0);

    // Backpressure: two words fill the buffer, the third waits
    out_ready[0] = 1'b0;
    push_word(0, 8'h11, 1'b0, 1'b0);
    push_word(0, 8'h22, 1'b0, 1'b0);
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h33;
    in_parity[0] = 1'b0;
    cyc(1);
    chk("bp full in_ready", 32'(in_ready[0]), 32'd0);
    cyc(1);
    chk("bp full in_ready 2", 32'(in_ready[0]), 32'd0);
    chk("bp held out_data", 32'(out_data[0]), 32'h11);
    chk("bp held out_valid", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    cyc(1);
    chk("bp in_ready after xfer", 32'(in_ready[0]), 32'd1);
    push_word(0, 8'h33, 1'b0, 1'b0);
    in_valid[0] = 1'b0;
    drain(0);
    chk("bp err_count unchanged", 32'(cnt0), 32'd1);

    // ODD=1 instance
    out_ready[1] = 1'b1;
    push_word(1, 8'h00, 1'b1, 1'b0);
    push_word(1, 8'h00, 1'b0, 1'b1);
    in_valid[1] = 1'b0;
    cyc(1);
    chk("odd err_count", 32'(cnt1), 32'd1);
    drain(1);
    clr_err[1] = 1'b1;
    cyc(1);
    clr_err[1] = 1'b0;
    chk("clr pre-sat count", 32'(cnt1), 32'd0);
    chk("clr pre-sat sticky", 32'(err_sticky[1]), 32'd0);

    // Saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      push_word(1, sat_d[i], sat_p[i], 1'b1);
      chk($sformatf("sat count %0d", i), 32'(cnt1), 32'(sat_c[i]));
    end
    clr_err[1] = 1'b1;
    push_word(1, 8'h10, 1'b1, 1'b1);
    clr_err[1]  = 1'b0;
    in_valid[1] = 1'b0;
    chk("clr+err count", 32'(cnt1), 32'd1);
    chk("clr+err sticky", 32'(err_sticky[1]), 32'd1);
    clr_err[1] = 1'b1;
    cyc(1);
    clr_err[1] = 1'b0;
    chk("clr alone count", 32'(cnt1), 32'd0);
    chk("clr alone sticky", 32'(err_sticky[1]), 32'd0);
    drain(1);

    // Mid-operation reset drops the buffered words
    out_ready[0] = 1'b0;
    push_word(0, 8'h07, 1'b0, 1'b1);
    push_word(0, 8'h55, 1'b0, 1'b0);
    in_valid[0] = 1'b0;
    chk("pre-rst err_count", 32'(cnt0), 32'd2);
    chk("pre-rst out_valid", 32'(out_valid[0]), 32'd1);
    rst = 1'b1;
    q0.delete();
    cyc(1);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst in_ready", 32'(in_ready[0]), 32'd1);
    chk("midrst err_count", 32'(cnt0), 32'd0);
    chk("midrst err_sticky", 32'(err_sticky[0]), 32'd0);
    out_ready[0] = 1'b1;
    cyc(5);
    chk("midrst no output", 32'(out_valid[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/parity_check_stage.md
Name: parity_check_stage

Overview:
Pipeline stage placed directly downstream of the parity generator. It accepts a data word plus its parity bit over a valid/ready handshake and recomputes parity. It forwards the word with a per-word error flag through a 2-entry skid buffer, so in_ready is registered. It also keeps a saturating error counter and a sticky error flag for status/debug readout.

Parameters:
WIDTH, 8, data word width in bits (>=1)
ODD, 0, 0: in_parity is expected to equal XOR of in_data; 1: in_parity is expected to equal inverted XOR of in_data
CNT_WIDTH, 8, width of error counter (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  stage can accept a word (registered)
in_data  input  WIDTH  data word
in_parity  input  1  parity bit produced upstream
out_valid  output  1  downstream word valid
out_ready  input  1  downstream accepts word
out_data  output  WIDTH  forwarded data word
out_error  output  1  parity mismatch for the word on out_data
err_count  output  CNT_WIDTH  number of mismatched words accepted, saturating
err_sticky  output  1  set on any accepted mismatch, held until cleared
clr_err  input  1  synchronous clear of err_count and err_sticky

Behaviour:
- Reset: one clock and a synchronous, active-high reset. On rst=1 at a rising edge: buffer empty, out_valid=0, in_ready=1, out_data=0, out_error=0, err_count=0, err_sticky=0. Reset mid-transfer drops all buffered words.
- Mismatch computation: err = (^in_data) ^ in_parity ^ ODD. It is computed combinationally at the input and stored with the word.
- Input accept: a word is accepted when in_valid && in_ready at the edge. Output transfer: a word is transferred when out_valid && out_ready.
- Buffer: 2 entries of {data, err}. Head drives out_data/out_error. out_valid = count!=0.
- in_ready is a register, equal to (count_next < 2). It never depends combinationally on out_ready.
- Latency: an accepted word appears on the outputs the cycle after acceptance (1-cycle latency). Throughput is 1 word/cycle when out_ready is held high.
- Order is preserved (FIFO). Simultaneous accept and transfer leaves count unchanged, and data advances correctly at count 1 and at count 2.
- Full (count=2): in_ready=0. An in_valid seen while in_ready=0 is ignored.
- Empty (count=0): out_valid=0. out_data/out_error hold their last value. No bypass path from input to output in the same cycle.
- While out_valid=1 and out_ready=0: out_data and out_error are held stable.
- err_count increments by 1 on each accepted word with err=1. It saturates at 2^CNT_WIDTH-1 and does not wrap.
- err_sticky is set on each accepted word with err=1.
- Simultaneous clr_err and an erroneous accept in the same cycle: the clear applies first, so the result is err_count=1, err_sticky=1.
- clr_err with no erroneous accept: err_count=0, err_sticky=0.
- Counters count at accept time, not at output transfer.

Test Plan:
- Reset then idle: rst high 2 cycles -> out_valid=0, in_ready=1, err_count=0, err_sticky=0. Sending no words leaves all outputs unchanged.
- Streaming, WIDTH=8, ODD=0, out_ready=1: send 0xA5/p=0, 0x01/p=1, 0x03/p=1 on consecutive cycles -> outputs 0xA5 err=0, 0x01 err=0, 0x03 err=1, each 1 cycle after accept. Result: err_count=1, err_sticky=1.
- Backpressure: out_ready=0 with 3 words offered -> first 2 accepted, then in_ready=0 and the third is held. Raise out_ready -> words emerge in order, no loss or duplication, and in_ready returns to 1 the cycle after the first transfer.
- ODD=1 instance: send 0x00/p=1 -> err=0; send 0x00/p=0 -> err=1.
- Saturation, CNT_WIDTH=2: send 5 bad words -> err_count sequence 1,2,3,3,3. Assert clr_err together with a 6th bad word -> err_count=1, err_sticky=1. Then clr_err alone -> err_count=0, err_sticky=0.
- Mid-operation reset: buffer holding 2 words with out_ready=0, assert rst -> next cycle out_valid=0, in_ready=1, err_count=0. Buffered words are never output.
